// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler
//   Paces audio samples toward the DAC async FIFO. Two producers (CPU MMIO
//   stream and the synth engine) share a small local buffer via round-robin
//   arbitration; a programmable divider releases exactly one sample per
//   period. On underrun the last emitted sample is repeated so the DAC holds
//   its level instead of glitching.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   cfg_en, cfg_div        pacing enable, sample period minus 1 (clk cycles)
//   cpu_valid/data/ready   CPU requester handshake
//   syn_valid/data/ready   synth requester handshake
//   out_full               async FIFO full (stalls issue)
//   out_valid, out_data    async FIFO w_en / w_data, one pulse per sample
//   level                  buffer occupancy 0..DEPTH
//   underrun, missed       sticky status flags, cleared by status_clr
//   status_clr             clears the sticky flags (a same-cycle set wins)
module audio_sample_scheduler #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic [DIV_WIDTH-1:0]     cfg_div,
    input  logic                     cpu_valid,
    input  logic [WIDTH-1:0]         cpu_data,
    output logic                     cpu_ready,
    input  logic                     syn_valid,
    input  logic [WIDTH-1:0]         syn_data,
    output logic                     syn_ready,
    input  logic                     out_full,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic                     missed,
    input  logic                     status_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [WIDTH-1:0]     last_sample;
    logic [DIV_WIDTH-1:0] div;
    logic                 pend;
    // Set when the most recent transfer came from the synth, so the CPU is
    // preferred at the next contention. Reset value gives the CPU first win.
    logic                 last_syn;

    logic                 full;
    logic                 empty;
    logic                 grant_cpu;
    logic                 grant_syn;
    logic                 push;
    logic [WIDTH-1:0]     push_data;
    logic                 tick;
    logic                 service;
    logic                 pop;

    always_comb begin
        full      = (level == LVL_FULL);
        empty     = (level == '0);
        grant_cpu = cpu_valid && (!syn_valid || last_syn);
        grant_syn = syn_valid && (!cpu_valid || !last_syn);
        // Fullness is taken from the registered level: a pop in the same
        // cycle does not open a slot for a push.
        cpu_ready = grant_cpu && !full;
        syn_ready = grant_syn && !full;
        push      = (cpu_valid && cpu_ready) || (syn_valid && syn_ready);
        push_data = grant_cpu ? cpu_data : syn_data;
        // >= rather than == so that lowering cfg_div below the running count
        // fires on the next cycle instead of waiting for a counter wrap.
        tick      = cfg_en && (div >= cfg_div);
        service   = pend && !out_full;
        pop       = service && !empty;
    end

    // Buffer storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_syn <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                last_syn <= grant_syn;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !cfg_en) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_WIDTH'(1);
        end
    end

    // Issue stage: registered one cycle after the service decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= MID;
            last_sample <= MID;
            underrun    <= 1'b0;
            missed      <= 1'b0;
        end else begin
            pend      <= tick || (pend && !service);
            out_valid <= service;
            if (service) begin
                if (!empty) begin
                    out_data    <= mem[rd_ptr];
                    last_sample <= mem[rd_ptr];
                end else begin
                    out_data <= last_sample;
                end
            end
            if (service && empty) begin
                underrun <= 1'b1;
            end else if (status_clr) begin
                underrun <= 1'b0;
            end
            if (tick && pend && !service) begin
                missed <= 1'b1;
            end else if (status_clr) begin
                missed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
module tb_audio_sample_scheduler;

    localparam int WIDTH     = 12;
    localparam int DEPTH     = 8;
    localparam int DIV_WIDTH = 16;
    localparam logic [WIDTH-1:0] MID = 12'h800;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_en;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 cpu_valid;
    logic [WIDTH-1:0]     cpu_data;
    logic                 cpu_ready;
    logic                 syn_valid;
    logic [WIDTH-1:0]     syn_data;
    logic                 syn_ready;
    logic                 out_full;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [3:0]           level;
    logic                 underrun;
    logic                 missed;
    logic                 status_clr;

    always #5 clk = ~clk;

    audio_sample_scheduler #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_WIDTH(DIV_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_div(cfg_div),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .syn_valid(syn_valid), .syn_data(syn_data), .syn_ready(syn_ready),
        .out_full(out_full), .out_valid(out_valid), .out_data(out_data),
        .level(level), .underrun(underrun), .missed(missed),
        .status_clr(status_clr)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Pending samples per producer; the head is presented until accepted.
    logic [WIDTH-1:0] cpu_src[$];
    logic [WIDTH-1:0] syn_src[$];

    // Reference model state.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] m_data;
    int               m_cnt;
    bit               m_pend, m_und, m_mis, m_vld;
    bit               m_prefer_cpu;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last       = MID;
        m_data       = MID;
        m_cnt        = 0;
        m_pend       = 0;
        m_und        = 0;
        m_mis        = 0;
        m_vld        = 0;
        m_prefer_cpu = 1;
    endtask

    task automatic step();
        bit is_full, want_cpu, want_syn, tick, service, set_u, set_m;
        cpu_valid = (cpu_src.size() != 0);
        if (cpu_valid) cpu_data = cpu_src[0];
        else           cpu_data = WIDTH'($urandom);
        syn_valid = (syn_src.size() != 0);
        if (syn_valid) syn_data = syn_src[0];
        else           syn_data = WIDTH'($urandom);
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            is_full  = (mq.size() == DEPTH);
            // Who would win if the buffer had room.
            want_cpu = cpu_valid && (!syn_valid || m_prefer_cpu);
            want_syn = syn_valid && !want_cpu;
            chk("cpu_ready", cpu_ready, want_cpu && !is_full);
            chk("syn_ready", syn_ready, want_syn && !is_full);
            if (cfg_en) begin
                tick  = (m_cnt >= int'(cfg_div));
                m_cnt = tick ? 0 : m_cnt + 1;
            end else begin
                tick  = 0;
                m_cnt = 0;
            end
            service = m_pend && !out_full;
            set_u   = 0;
            m_vld   = service;
            if (service) begin
                if (mq.size() != 0) begin
                    m_data = mq.pop_front();
                    m_last = m_data;
                end else begin
                    m_data = m_last;
                    set_u  = 1;
                end
            end
            set_m  = tick && m_pend && !service;
            m_pend = tick || (m_pend && !service);
            m_und  = set_u ? 1'b1 : (status_clr ? 1'b0 : m_und);
            m_mis  = set_m ? 1'b1 : (status_clr ? 1'b0 : m_mis);
            if (!is_full && want_cpu) begin
                mq.push_back(cpu_data);
                void'(cpu_src.pop_front());
                m_prefer_cpu = 0;
            end else if (!is_full && want_syn) begin
                mq.push_back(syn_data);
                void'(syn_src.pop_front());
                m_prefer_cpu = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("out_valid", out_valid, m_vld);
        chk("out_data", out_data, m_data);
        chk("level", level, mq.size());
        chk("underrun", underrun, m_und);
        chk("missed", missed, m_mis);
    endtask

    initial begin
        rst = 1; cfg_en = 0; cfg_div = '0; out_full = 0; status_clr = 0;
        cpu_valid = 0; syn_valid = 0; cpu_data = '0; syn_data = '0;
        model_reset();
        step();
        step();
        rst = 0;

        // Pacing at a 10-cycle period, then an underrun repeat of 0x300.
        cpu_src.push_back(12'h100);
        cpu_src.push_back(12'h200);
        cpu_src.push_back(12'h300);
        cfg_div = 16'd9;
        cfg_en  = 1;
        repeat (45) step();
        status_clr = 1; step(); status_clr = 0;

        // Arbitration with pacing off until the buffer fills.
        cfg_en = 0;
        for (int i = 0; i < 10; i++) begin
            cpu_src.push_back(WIDTH'(12'hA00 + i));
            syn_src.push_back(WIDTH'(12'hB00 + i));
        end
        repeat (12) step();
        cpu_src.delete();
        syn_src.delete();

        // Tick every cycle: drain 8, then repeat with underrun.
        cfg_div = '0;
        cfg_en  = 1;
        repeat (12) step();
        status_clr = 1; step(); status_clr = 0;

        // Backpressure from the async FIFO.
        cpu_src.push_back(12'h111);
        cpu_src.push_back(12'h222);
        cpu_src.push_back(12'h333);
        cfg_div  = 16'd9;
        out_full = 1;
        repeat (25) step();
        out_full = 0;
        repeat (6) step();
        status_clr = 1; step(); status_clr = 0;

        // Lowering the period below the running count.
        rst = 1; step(); rst = 0;
        cfg_div = 16'd100;
        cfg_en  = 1;
        repeat (50) step();
        cfg_div = 16'd3;
        repeat (16) step();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 39) == 0) cfg_div = DIV_WIDTH'($urandom_range(0, 6));
            if ($urandom_range(0, 59) == 0) cfg_en = !cfg_en;
            out_full   = ($urandom_range(0, 3) == 0);
            status_clr = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            if (cpu_src.size() < 3 && $urandom_range(0, 2) == 0)
                cpu_src.push_back(WIDTH'($urandom));
            if (syn_src.size() < 3 && $urandom_range(0, 2) == 0)
                syn_src.push_back(WIDTH'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
